rf_buf_arb: RTL

- Controller and arbiter for the RF disk controller's 256x12 sector buffer RAM.
- Shares the single RAM port between two requesters:
  - Requester A: CPU/data-break side, random access.
  - Requester B: disk-side serializer, sequential access through an internal auto-incrementing pointer.
- Also sequences a hardware buffer clear that writes zero to all 256 words.
- Sits between the RF control logic and the buffer RAM instance.

---
 rtl/rf_buf_arb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rf_buf_arb.sv
// rf_buf_arb: controller and arbiter for the RF disk controller sector buffer.
// It shares one RAM port between two requesters:
//   A - CPU / data-break side, random access (a_*)
//   B - disk-side serializer, sequential access through b_ptr (b_*)
// It also runs a hardware clear that writes zero to every buffer word.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_din -> a_dout/a_ack   A access, level req held until ack
//   b_req/b_we/b_din        -> b_dout/b_ack   B access at b_ptr
//   b_start                 pulse: rewind b_ptr, clear b_wrap
//   b_ptr, b_wrap           B pointer and sticky wrap flag
//   clr_start -> busy       buffer clear request / in progress
//   ram_a/ram_din/ram_ce/ram_we, ram_dout      RAM port (read is combinational)
module rf_buf_arb #(
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    output logic          a_ack,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          b_ack,
    input  logic          b_start,
    output logic [AW-1:0] b_ptr,
    output logic          b_wrap,
    input  logic          clr_start,
    output logic          busy,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    output logic          ram_ce,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {IDLE, GNT_A, GNT_B, ACK, CLEAR} state_e;

    state_e        state_q, state_d;
    logic          last_b_q, last_b_d;   // 1: B was granted last
    logic          gnt_b_q, gnt_b_d;     // access in flight belongs to B
    logic          lat_we_q, lat_we_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [DW-1:0] lat_din_q, lat_din_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [AW-1:0] b_ptr_q;
    logic          b_wrap_q;
    logic [DW-1:0] a_dout_q, b_dout_q;
    logic          a_ack_q, b_ack_q;

    // State register plus request latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;   // A wins the first tie
            gnt_b_q    <= 1'b0;
            lat_we_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_din_q  <= '0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            gnt_b_q    <= gnt_b_d;
            lat_we_q   <= lat_we_d;
            lat_addr_q <= lat_addr_d;
            lat_din_q  <= lat_din_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        gnt_b_d    = gnt_b_q;
        lat_we_d   = lat_we_q;
        lat_addr_d = lat_addr_q;
        lat_din_d  = lat_din_q;
        clr_cnt_d  = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (a_req && (!b_req || last_b_q)) begin
                    state_d    = GNT_A;
                    last_b_d   = 1'b0;
                    gnt_b_d    = 1'b0;
                    lat_we_d   = a_we;
                    lat_addr_d = a_addr;
                    lat_din_d  = a_din;
                end else if (b_req) begin
                    state_d    = GNT_B;
                    last_b_d   = 1'b1;
                    gnt_b_d    = 1'b1;
                    lat_we_d   = b_we;
                    lat_addr_d = b_ptr_q;
                    lat_din_d  = b_din;
                end
            end
            GNT_A, GNT_B: state_d = ACK;
            ACK:          state_d = IDLE;
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {AW{1'b1}}) state_d = IDLE;
            end
            default:      state_d = IDLE;
        endcase
    end

    // Read capture, acks and the B pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            b_ptr_q  <= '0;
            b_wrap_q <= 1'b0;
        end else begin
            if (state_q == GNT_A && !lat_we_q) a_dout_q <= ram_dout;
            if (state_q == GNT_B && !lat_we_q) b_dout_q <= ram_dout;
            a_ack_q <= (state_q == GNT_A);
            b_ack_q <= (state_q == GNT_B);
            // Rewind wins over the increment of a completing B access
            if (b_start) begin
                b_ptr_q  <= '0;
                b_wrap_q <= 1'b0;
            end else if (state_q == ACK && gnt_b_q) begin
                b_ptr_q <= b_ptr_q + 1'b1;
                if (b_ptr_q == {AW{1'b1}}) b_wrap_q <= 1'b1;
            end
        end
    end

    // Outputs decoded from registered state. Enables are gated by reset so
    // an aborted access or clear never performs its final write.
    always_comb begin
        ram_ce  = 1'b0;
        ram_we  = 1'b0;
        ram_a   = '0;
        ram_din = '0;
        case (state_q)
            GNT_A, GNT_B: begin
                ram_ce  = ~reset;
                ram_we  = lat_we_q & ~reset;
                ram_a   = lat_addr_q;
                ram_din = lat_din_q;
            end
            CLEAR: begin
                ram_ce = ~reset;
                ram_we = ~reset;
                ram_a  = clr_cnt_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q == CLEAR);
    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;
    assign a_ack  = a_ack_q;
    assign b_ack  = b_ack_q;
    assign b_ptr  = b_ptr_q;
    assign b_wrap = b_wrap_q;

endmodule
